sram_1r1w_masked_init: RTL and testbench
========================================

// Module: sram_1r1w_masked_init
// PURPOSE
// - Parametrised single-clock 1R1W SRAM for L2 tag/data/state arrays.
// - Next generation of the fixed 19x128 dual-port model; adds byte write mask,
//   deterministic read/write collision handling and a selectable read latency.
// - Adds a reset-time clear sweep, so no array entry ever reads X after reset.
// PARAMETERS
// - DATA_WIDTH     32  word width in bits; must be a multiple of 8 (elaboration $error otherwise)
// - DEPTH          128 number of words; power of 2 not required
// - ADDR_WIDTH     $clog2(DEPTH) derived; do not override
// - WMASK_WIDTH    DATA_WIDTH/8 derived; one mask bit per byte
// - READ_LATENCY   1   1 or 2 cycles from read request to dout1 (any other value: $error)
// - BYPASS         1   1: same-address read returns newly written bytes; 0: returns old data
// - CLEAR_ON_RESET 1   1: zero every word after reset; 0: skip the sweep
// PORTS
// - clk     in  1            single clock, all state on posedge
// - rstb    in  1            synchronous active-low reset
// - csb0    in  1            write port select, active low
// - addr0   in  ADDR_WIDTH   write address
// - din0    in  DATA_WIDTH   write data
// - wmask0  in  WMASK_WIDTH  byte write enables, bit i covers din0[8i+7:8i]
// - csb1    in  1            read port select, active low
// - addr1   in  ADDR_WIDTH   read address
// - dout1   out DATA_WIDTH   read data
// - dout1_v out 1            one-cycle pulse: dout1 carries a new read result
// - busy    out 1            high while in reset or clearing; requests are ignored
// BEHAVIOUR
// - Reset (rstb=0 at posedge): dout1=0, dout1_v=0, busy=1, read pipeline flushed,
//   clr_addr=0, FSM=CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0).
// - FSM CLEAR: each cycle writes all-zero to mem[clr_addr] and increments clr_addr.
//   Moves to READY on the edge that writes DEPTH-1; busy falls that edge.
//   The sweep therefore takes DEPTH cycles after rstb rises.
// - Reset asserted during CLEAR restarts the sweep at address 0.
// - In CLEAR, csb0/csb1 are ignored; no write occurs, dout1_v stays 0.
// - Write (READY, csb0=0 at posedge N): bytes with wmask0[i]=1 update mem[addr0];
//   unmasked bytes keep their value; wmask0=0 performs no write.
//   A read sampled at edge N+1 or later sees the new data.
// - Read (READY, csb1=0 at posedge N): with READ_LATENCY=1, dout1/dout1_v update at
//   edge N; with 2, at edge N+1. Back-to-back reads give one result per cycle.
// - With no read, dout1 holds its last value (never X); dout1_v=0.
// - Collision (both selected, addr0==addr1, same edge):
//   - BYPASS=1: result = din0 bytes where wmask0=1, old bytes elsewhere.
//   - BYPASS=0: result = old word (read-before-write).
//   - The write always completes.
// - Address >= DEPTH: the write is dropped; a read returns 0 with dout1_v=1.
// - No $display in synthesisable paths; no # delays.
// STRUCTURE
// - sram_pkg: clr_state_e {CLEAR, READY}; localparams LAT1/LAT2; function
//   byte_merge(old, new, mask) shared by the write path and the bypass path.
// - Sub-module sram_1r1w_array: bare storage (1 write port with byte enables,
//   1 registered read port, no reset). Owns mem[]; the top owns FSM, mux, pipeline.
// TESTING (DATA_WIDTH=32, DEPTH=16 unless noted)
// - Reset, then read all 16 addresses: busy high 16 cycles after rstb rises; every read = 0.
// - Write 0xDEADBEEF @3 mask 4'b1111, then @3 0x00001122 mask 4'b0011; read @3 -> 0xDEAD1122.
// - Collision @5 (old 0xAAAAAAAA), write 0x11223344 mask 4'b0101:
//   BYPASS=1 -> 0xAA22AA44; BYPASS=0 -> 0xAAAAAAAA; both then read 0xAA22AA44.
// - READ_LATENCY=2, reads @0..@3 on consecutive edges: dout1_v high 4 consecutive cycles, delayed one cycle vs latency 1.
// - rstb low 1 cycle at clr_addr=9: sweep restarts at 0; busy lasts 16 more cycles; writes issued during busy are lost.
// - DEPTH=12, read @13 -> 0 with dout1_v=1; write @13 leaves @1 and @13 unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared types, latency constants and byte-merge helper for the 1R1W SRAM.
package sram_pkg;
    typedef enum logic {CLEAR, READY} clr_state_e;
    localparam int LAT1 = 1;
    localparam int LAT2 = 2;
    // Widest word the merge helper handles; callers cast to/from their own width.
    localparam int MAX_DW = 256;
    localparam int MAX_MW = MAX_DW / 8;
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_MW-1:0] mask
    );
        logic [MAX_DW-1:0] r;
        for (int i = 0; i < MAX_MW; i++) r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/sram_1r1w_array.sv
// sram_1r1w_array: bare storage with one byte-masked write port and one registered read port.
module sram_1r1w_array
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 128,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic                   re,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]  rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read and write on the same edge return the old word; bypass lives in the top.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= DATA_WIDTH'(byte_merge(MAX_DW'(mem[waddr]), MAX_DW'(wdata), MAX_MW'(wmask)));
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sram_1r1w_masked_init.sv
// sram_1r1w_masked_init: 1R1W SRAM with byte mask, collision bypass, 1/2-cycle read latency
// and a post-reset zero sweep.
module sram_1r1w_masked_init
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 128,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int WMASK_WIDTH    = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   csb0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_v,
    output logic                   busy
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8 and at most MAX_DW");
    end
    if (READ_LATENCY != LAT1 && READ_LATENCY != LAT2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    clr_state_e              state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    clearing, ready, in0, in1, wr_ok, we, re, hit;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata, rdata, s1_data, byp_data;
    logic [WMASK_WIDTH-1:0]  wmask, byp_mask;
    logic                    s1_v, s1_zero, s1_hit;

    assign clearing = rstb && state == CLEAR;
    assign ready    = rstb && state == READY;
    assign in0      = {1'b0, addr0} < DEPTH_W;
    assign in1      = {1'b0, addr1} < DEPTH_W;
    assign wr_ok    = ready && !csb0 && in0;
    assign re       = ready && !csb1;
    assign we       = clearing || (wr_ok && |wmask0);
    assign waddr    = clearing ? clr_addr : addr0;
    assign wdata    = clearing ? '0 : din0;
    assign wmask    = clearing ? '1 : wmask0;
    assign hit      = BYPASS != 0 && wr_ok && addr0 == addr1;

    sram_1r1w_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WMASK_WIDTH(WMASK_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .wmask(wmask),
        .re   (re && in1),
        .raddr(addr1),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state    <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
            clr_addr <= '0;
            busy     <= 1'b1;
            s1_v     <= 1'b0;
            s1_zero  <= 1'b1;
            s1_hit   <= 1'b0;
        end else begin
            busy <= clearing && clr_addr != LAST;
            s1_v <= re;
            if (clearing) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == LAST) state <= READY;
            end
            // Stage-1 qualifiers only move on a read so dout1 holds between reads.
            if (re) begin
                s1_zero  <= !in1;
                s1_hit   <= hit;
                byp_data <= din0;
                byp_mask <= wmask0;
            end
        end
    end

    assign s1_data = s1_zero ? '0
                   : s1_hit ? DATA_WIDTH'(byte_merge(MAX_DW'(rdata), MAX_DW'(byp_data), MAX_MW'(byp_mask)))
                   : rdata;

    if (READ_LATENCY == LAT2) begin : g_lat2
        logic [DATA_WIDTH-1:0] d2;
        logic                  v2;
        always_ff @(posedge clk) begin
            if (!rstb) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else begin
                v2 <= s1_v;
                if (s1_v) d2 <= s1_data;
            end
        end
        assign dout1   = d2;
        assign dout1_v = v2;
    end else begin : g_lat1
        assign dout1   = s1_data;
        assign dout1_v = s1_v;
    end
endmodule

// File: tb/tb_sram_1r1w_masked_init.sv
// tb_sram_1r1w_masked_init: four configurations driven by shared directed vectors,
// each checked by a queue-based scoreboard monitor.
module tb_sram_1r1w_masked_init;
    logic        clk = 1'b0;
    logic        rstb, csb0, csb1;
    logic [3:0]  addr0, addr1, wmask0;
    logic [31:0] din0;
    logic [31:0] dout [4];
    logic        dv   [4];
    logic        busy [4];
    logic [31:0] q    [4][$];
    int          errors = 0;
    int          checks = 0;
    int          na, nd;

    always #5 clk = ~clk;

    // a: defaults (DEPTH 16), b: BYPASS=0, c: READ_LATENCY=2, d: DEPTH=12
    sram_1r1w_masked_init #(.DATA_WIDTH(32), .DEPTH(16)) u_a (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout[0]), .dout1_v(dv[0]), .busy(busy[0]));
    sram_1r1w_masked_init #(.DATA_WIDTH(32), .DEPTH(16), .BYPASS(0)) u_b (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout[1]), .dout1_v(dv[1]), .busy(busy[1]));
    sram_1r1w_masked_init #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(2)) u_c (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout[2]), .dout1_v(dv[2]), .busy(busy[2]));
    sram_1r1w_masked_init #(.DATA_WIDTH(32), .DEPTH(12)) u_d (
        .clk(clk), .rstb(rstb), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
        .csb1(csb1), .addr1(addr1), .dout1(dout[3]), .dout1_v(dv[3]), .busy(busy[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dv[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read dut%0d: got %h expected no result", k, dout[k]);
                end else begin
                    chk($sformatf("dout1 dut%0d", k), dout[k], q[k].pop_front());
                end
            end
        end
    end

    task automatic cyc(input bit w, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] wm,
                       input bit r, input logic [3:0] ra,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec, input logic [31:0] ed);
        @(negedge clk);
        csb0 = !w; addr0 = wa; din0 = wd; wmask0 = wm;
        csb1 = !r; addr1 = ra;
        if (r) begin
            q[0].push_back(ea); q[1].push_back(eb); q[2].push_back(ec); q[3].push_back(ed);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        cyc(1, a, d, m, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        cyc(0, 0, 0, 0, 1, a, e, e, e, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] va, vc;
        logic [6:0] exp_a, exp_c;
        rstb = 0; csb0 = 1; csb1 = 1; addr0 = 0; addr1 = 0; din0 = 0; wmask0 = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset dout1 dut%0d", k), dout[k], 32'h0);
            chk($sformatf("reset dout1_v dut%0d", k), {31'b0, dv[k]}, 32'h0);
            chk($sformatf("reset busy dut%0d", k), {31'b0, busy[k]}, 32'h1);
        end
        @(negedge clk);
        rstb = 1;
        na = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy[0]) na++;
            if (busy[3]) nd++;
            rd(4'(i % 4), 0);
            if (i < 15) begin
                csb1 = 1;
                for (int k = 0; k < 4; k++) void'(q[k].pop_back());
            end
        end
        chk("busy cycles depth16", na, 16);
        chk("busy cycles depth12", nd, 12);
        for (int a = 0; a < 16; a++) rd(4'(a), 0);
        wr(3, 32'hDEADBEEF, 4'b1111);
        wr(3, 32'h00001122, 4'b0011);
        rd(3, 32'hDEAD1122);
        wr(5, 32'hAAAAAAAA, 4'b1111);
        cyc(1, 5, 32'h11223344, 4'b0101, 1, 5, 32'hAA22AA44, 32'hAAAAAAAA, 32'hAA22AA44, 32'hAA22AA44);
        rd(5, 32'hAA22AA44);
        wr(9, 32'h55667788, 4'b0000);
        rd(9, 0);
        cyc(0, 0, 0, 0, 1, 13, 0, 0, 0, 0);
        wr(13, 32'h12345678, 4'b1111);
        cyc(0, 0, 0, 0, 1, 13, 32'h12345678, 32'h12345678, 32'h12345678, 0);
        rd(1, 0);
        wr(0, 32'hA0A0A0A0, 4'b1111);
        wr(1, 32'hB1B1B1B1, 4'b1111);
        wr(2, 32'hC2C2C2C2, 4'b1111);
        idle(); idle();
        exp_a = 7'b0011110;
        exp_c = 7'b0111100;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: rd(0, 32'hA0A0A0A0);
                1: rd(1, 32'hB1B1B1B1);
                2: rd(2, 32'hC2C2C2C2);
                3: rd(3, 32'hDEAD1122);
                default: idle();
            endcase
            va = {1'b0, dv[0]};
            vc = {1'b0, dv[2]};
            chk($sformatf("lat1 valid step%0d", k), {30'b0, va}, {31'b0, exp_a[k]});
            chk($sformatf("lat2 valid step%0d", k), {30'b0, vc}, {31'b0, exp_c[k]});
        end
        @(negedge clk);
        rstb = 0;
        @(negedge clk);
        rstb = 1;
        repeat (9) @(negedge clk);
        rstb = 0;
        @(negedge clk);
        rstb = 1;
        na = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy[0]) na++;
            if (busy[3]) nd++;
            if (i < 10) begin
                cyc(1, 0, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 0, 0, 0);
                csb1 = 0; addr1 = 0;
            end else idle();
        end
        chk("restart busy depth16", na, 16);
        chk("restart busy depth12", nd, 12);
        rd(0, 0);
        rd(3, 0);
        repeat (4) idle();
        for (int k = 0; k < 4; k++) chk($sformatf("queue drained dut%0d", k), q[k].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
